// File: rtl/weight_buf_pkg.sv
// Shared types for the weight bank ring: bank lifecycle states, tile length type,
// protocol error codes and the ring pointer wrap helper.
package weight_buf_pkg;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankReady,
    BankDraining
  } bank_state_e;

  // Wide enough for a full tile of up to 65536 words.
  localparam int unsigned MaxTileLenW = 17;
  typedef logic [MaxTileLenW-1:0] tile_len_t;

  localparam logic [1:0] ErrNone        = 2'd0;
  localparam logic [1:0] ErrReadUnavail = 2'd1;
  localparam logic [1:0] ErrReleaseIdle = 2'd2;

  // Ring pointers wrap explicitly so non-power-of-two bank counts work.
  function automatic int unsigned next_bank(input int unsigned idx, input int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wbr_bank_ram.sv
// One weight bank: simple dual-port RAM, one write and one registered read per cycle.
module wbr_bank_ram #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_bank_ring.sv
// N-bank ring of weight tile buffers between the DMA write path and the weight loader.
// Producer and consumer walk the ring independently; a tile may be rewound and replayed.
module weight_bank_ring
  import weight_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int unsigned AF_TH      = 4,
  parameter int unsigned AE_TH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic                  wr_almost_full,
  output logic                  wt_load_done,
  output logic [BANK_W-1:0]     wr_bank,
  input  logic                  rd_en,
  input  logic                  rd_rewind,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_dvalid,
  output logic                  rd_almost_empty,
  output logic                  rd_tile_done,
  output logic [BANK_W-1:0]     rd_bank,
  output logic [ADDR_WIDTH:0]   rd_tile_len,
  output logic [BANK_W:0]       banks_ready,
  output logic                  err_sticky
);

  localparam int unsigned LenW = ADDR_WIDTH + 1;

  bank_state_e           state_q [NUM_BANKS];
  bank_state_e           state_d [NUM_BANKS];
  logic [LenW-1:0]       len_q   [NUM_BANKS];
  logic [LenW-1:0]       len_d   [NUM_BANKS];

  logic [BANK_W-1:0]     wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]     rd_bank_q, rd_bank_d;
  logic [BANK_W-1:0]     rd_sel_q;
  logic [LenW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [LenW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                  load_done_q;
  logic                  rd_dvalid_q;
  logic                  err_q;
  logic [1:0]            err_code;

  bank_state_e           fill_state, drain_state;
  logic                  fill_open, drain_open;
  logic                  wr_accept, rd_accept;
  logic [LenW-1:0]       drain_len;
  logic [31:0]           free_words, unread_words;
  logic [NUM_BANKS-1:0]  bank_we, bank_re;
  logic [DATA_WIDTH-1:0] ram_rdata [NUM_BANKS];
  logic [BANK_W:0]       ready_cnt;

  assign fill_state  = state_q[wr_bank_q];
  assign drain_state = state_q[rd_bank_q];
  assign drain_len   = len_q[rd_bank_q];
  assign fill_open   = (fill_state == BankEmpty) || (fill_state == BankFilling);
  assign drain_open  = (drain_state == BankReady) || (drain_state == BankDraining);

  assign wr_ready  = fill_open && (32'(wr_cnt_q) < DEPTH);
  assign wr_accept = wr_valid && wr_ready;
  assign rd_avail  = drain_open && (rd_ptr_q < drain_len);
  assign rd_accept = rd_en && rd_avail;

  // A fill bank that is not writable (ring full) reports zero free words.
  assign free_words     = fill_open ? (DEPTH - 32'(wr_cnt_q)) : 32'd0;
  assign wr_almost_full = free_words <= AF_TH;
  assign unread_words   = 32'(drain_len) - 32'(rd_ptr_q);
  assign rd_almost_empty = drain_open && (unread_words <= AE_TH);
  assign rd_tile_done    = (drain_state == BankDraining) && (rd_ptr_q == drain_len);

  always_comb begin
    ready_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if ((state_q[i] == BankReady) || (state_q[i] == BankDraining)) begin
        ready_cnt = ready_cnt + (BANK_W + 1)'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      state_d[i] = state_q[i];
      len_d[i]   = len_q[i];
    end
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    err_code  = ErrNone;

    if (wr_accept) begin
      if (wr_last) begin
        len_d[wr_bank_q]   = wr_cnt_q + LenW'(1);
        state_d[wr_bank_q] = BankReady;
        wr_bank_d          = BANK_W'(next_bank(32'(wr_bank_q), NUM_BANKS));
        wr_cnt_d           = '0;
      end else begin
        state_d[wr_bank_q] = BankFilling;
        wr_cnt_d           = wr_cnt_q + LenW'(1);
      end
    end

    if (rd_accept) begin
      rd_ptr_d           = rd_ptr_q + LenW'(1);
      state_d[rd_bank_q] = BankDraining;
    end else if (rd_en) begin
      err_code = ErrReadUnavail;
    end

    // Release outranks rewind; an accepted read in the same cycle has already been issued.
    if (rd_release) begin
      if (drain_open) begin
        state_d[rd_bank_q] = BankEmpty;
        rd_ptr_d           = '0;
        rd_bank_d          = BANK_W'(next_bank(32'(rd_bank_q), NUM_BANKS));
      end else begin
        err_code = ErrReleaseIdle;
      end
    end else if (rd_rewind) begin
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= BankEmpty;
        len_q[i]   <= '0;
      end
      wr_bank_q   <= '0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= '0;
      rd_ptr_q    <= '0;
      rd_sel_q    <= '0;
      load_done_q <= 1'b0;
      rd_dvalid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
      end
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_ptr_q    <= rd_ptr_d;
      load_done_q <= wr_accept && wr_last;
      rd_dvalid_q <= rd_accept;
      if (rd_accept) begin
        rd_sel_q <= rd_bank_q;
      end
      if (err_code != ErrNone) begin
        err_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    assign bank_we[g] = wr_accept && (wr_bank_q == BANK_W'(g));
    assign bank_re[g] = rd_accept && (rd_bank_q == BANK_W'(g));

    wbr_bank_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clk_i  (clk),
      .we_i   (bank_we[g]),
      .waddr_i(wr_cnt_q[ADDR_WIDTH-1:0]),
      .wdata_i(wr_data),
      .re_i   (bank_re[g]),
      .raddr_i(rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata_o(ram_rdata[g])
    );
  end

  // RAM output registers are not reset, so hide them until a read lands.
  assign rd_data      = rd_dvalid_q ? ram_rdata[rd_sel_q] : '0;
  assign rd_dvalid    = rd_dvalid_q;
  assign wt_load_done = load_done_q;
  assign wr_bank      = wr_bank_q;
  assign rd_bank      = rd_bank_q;
  assign rd_tile_len  = drain_len;
  assign banks_ready  = ready_cnt;
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_weight_bank_ring.sv
// Directed bench for weight_bank_ring (3 banks of 16 words) with a read-data scoreboard.
module tb_weight_bank_ring;

  localparam int unsigned DW  = 24;
  localparam int unsigned DEP = 16;
  localparam int unsigned AW  = 4;
  localparam int unsigned NB  = 3;
  localparam int unsigned BW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_last, wr_ready, wr_almost_full, wt_load_done;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_bank, rd_bank;
  logic          rd_en, rd_rewind, rd_release, rd_avail, rd_dvalid;
  logic          rd_almost_empty, rd_tile_done, err_sticky;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_tile_len;
  logic [BW:0]   banks_ready;

  weight_bank_ring #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEP),
    .ADDR_WIDTH(AW),
    .NUM_BANKS (NB),
    .BANK_W    (BW),
    .AF_TH     (4),
    .AE_TH     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_last        (wr_last),
    .wr_ready       (wr_ready),
    .wr_almost_full (wr_almost_full),
    .wt_load_done   (wt_load_done),
    .wr_bank        (wr_bank),
    .rd_en          (rd_en),
    .rd_rewind      (rd_rewind),
    .rd_release     (rd_release),
    .rd_avail       (rd_avail),
    .rd_data        (rd_data),
    .rd_dvalid      (rd_dvalid),
    .rd_almost_empty(rd_almost_empty),
    .rd_tile_done   (rd_tile_done),
    .rd_bank        (rd_bank),
    .rd_tile_len    (rd_tile_len),
    .banks_ready    (banks_ready),
    .err_sticky     (err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Bench-side model of the ring
  logic [DW-1:0] m_mem [NB][DEP];
  int m_len [NB];
  int m_wr_bank, m_wr_cnt, m_rd_bank, m_rd_ptr, m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if ((sb.size() > 0) && (sb[0].cyc == cyc)) begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_dvalid", 32'(rd_dvalid), 32'(1));
        chk("rd_data", 32'(rd_data), 32'(e.data));
      end else begin
        chk("rd_dvalid_idle", 32'(rd_dvalid), 32'(0));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_rewind = 1'b0; rd_release = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int b = 0; b < NB; b++) m_len[b] = 0;
    m_wr_bank = 0; m_wr_cnt = 0; m_rd_bank = 0; m_rd_ptr = 0; m_ready = 0;
    mon_en = 1'b1;
  endtask

  task automatic write_beats(input int n, input bit last, input bit rel);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      wr_valid   = 1'b1;
      wr_data    = d;
      wr_last    = last && (i == n - 1);
      rd_release = rel && (i == n - 1);
      chk("wr_ready", 32'(wr_ready), 32'(1));
      tick();
      m_mem[m_wr_bank][m_wr_cnt] = d;
      if (wr_last) begin
        m_len[m_wr_bank] = m_wr_cnt + 1;
        m_wr_bank = (m_wr_bank + 1) % NB;
        m_wr_cnt  = 0;
        m_ready++;
        chk("wt_load_done", 32'(wt_load_done), 32'(1));
      end else begin
        m_wr_cnt++;
      end
    end
    if (rel) begin
      m_ready--;
      m_rd_bank = (m_rd_bank + 1) % NB;
      m_rd_ptr  = 0;
    end
    wr_valid = 1'b0; wr_last = 1'b0; rd_release = 1'b0;
  endtask

  task automatic read_words(input int n, input bit rew, input bit rel);
    for (int i = 0; i < n; i++) begin
      rd_en      = 1'b1;
      rd_rewind  = rew && (i == n - 1);
      rd_release = rel && (i == n - 1);
      chk("rd_avail", 32'(rd_avail), 32'(1));
      sb.push_back('{data: m_mem[m_rd_bank][m_rd_ptr], cyc: cyc + 1});
      tick();
      m_rd_ptr++;
      if (rd_release) begin
        m_ready--;
        m_rd_bank = (m_rd_bank + 1) % NB;
        m_rd_ptr  = 0;
      end else if (rd_rewind) begin
        m_rd_ptr = 0;
      end
    end
    rd_en = 1'b0; rd_rewind = 1'b0; rd_release = 1'b0;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    m_ready--;
    m_rd_bank = (m_rd_bank + 1) % NB;
    m_rd_ptr  = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_wr_ready", 32'(wr_ready), 32'(1));
    chk("rst_wr_bank", 32'(wr_bank), 32'(0));
    chk("rst_rd_bank", 32'(rd_bank), 32'(0));
    chk("rst_banks_ready", 32'(banks_ready), 32'(0));
    chk("rst_rd_avail", 32'(rd_avail), 32'(0));
    chk("rst_rd_tile_len", 32'(rd_tile_len), 32'(0));
    chk("rst_err", 32'(err_sticky), 32'(0));
    chk("rst_wr_af", 32'(wr_almost_full), 32'(0));
    chk("rst_rd_ae", 32'(rd_almost_empty), 32'(0));
    chk("rst_load_done", 32'(wt_load_done), 32'(0));

    // 16-word tile, read back in order
    write_beats(11, 1'b0, 1'b0);
    write_beats(5, 1'b1, 1'b0);
    chk("t0_banks_ready", 32'(banks_ready), m_ready);
    chk("t0_tile_len", 32'(rd_tile_len), 32'(16));
    chk("t0_wr_bank", 32'(wr_bank), m_wr_bank);
    chk("t0_rd_ae", 32'(rd_almost_empty), 32'(0));
    tick();
    chk("t0_done_pulse", 32'(wt_load_done), 32'(0));
    read_words(11, 1'b0, 1'b0);
    chk("t0_ae_5left", 32'(rd_almost_empty), 32'(0));
    chk("t0_not_done", 32'(rd_tile_done), 32'(0));
    read_words(1, 1'b0, 1'b0);
    chk("t0_ae_4left", 32'(rd_almost_empty), 32'(1));
    read_words(4, 1'b0, 1'b0);
    chk("t0_tile_done", 32'(rd_tile_done), 32'(1));
    chk("t0_avail_end", 32'(rd_avail), 32'(0));
    release_bank();
    chk("t0_rel_ready", 32'(banks_ready), m_ready);
    chk("t0_rel_rd_bank", 32'(rd_bank), m_rd_bank);
    chk("t0_err", 32'(err_sticky), 32'(0));

    // Fill the whole ring (wrap 2 -> 0)
    write_beats(10, 1'b1, 1'b0);
    chk("ring_wr_bank_a", 32'(wr_bank), m_wr_bank);
    write_beats(3, 1'b1, 1'b0);
    chk("ring_wr_bank_b", 32'(wr_bank), m_wr_bank);
    write_beats(2, 1'b1, 1'b0);
    chk("ring_wr_bank_c", 32'(wr_bank), m_wr_bank);
    chk("ring_full_ready", 32'(wr_ready), 32'(0));
    chk("ring_banks_ready", 32'(banks_ready), 32'(3));
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = 24'h000BAD;
    tick();
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("ring_no_commit", 32'(wt_load_done), 32'(0));
    chk("ring_still_full", 32'(banks_ready), 32'(3));

    // Replay: read 5 (5th alongside rewind), then all 10
    read_words(4, 1'b0, 1'b0);
    read_words(1, 1'b1, 1'b0);
    read_words(10, 1'b0, 1'b0);
    chk("replay_done", 32'(rd_tile_done), 32'(1));
    release_bank();
    chk("replay_wr_ready", 32'(wr_ready), 32'(1));
    chk("replay_rd_bank", 32'(rd_bank), m_rd_bank);
    chk("replay_banks", 32'(banks_ready), m_ready);
    chk("replay_err", 32'(err_sticky), 32'(0));

    // Commit tile B in the same cycle as releasing an unread tile
    chk("cr_len_before", 32'(rd_tile_len), m_len[m_rd_bank]);
    write_beats(4, 1'b1, 1'b1);
    chk("cr_banks", 32'(banks_ready), 32'(2));
    chk("cr_rd_bank", 32'(rd_bank), m_rd_bank);
    chk("cr_wr_bank", 32'(wr_bank), m_wr_bank);
    chk("cr_len_after", 32'(rd_tile_len), m_len[m_rd_bank]);
    read_words(1, 1'b0, 1'b1);
    chk("rdrel_rd_bank", 32'(rd_bank), m_rd_bank);
    chk("rdrel_banks", 32'(banks_ready), m_ready);
    chk("rdrel_len", 32'(rd_tile_len), 32'(4));
    read_words(4, 1'b0, 1'b0);
    release_bank();
    chk("drained_banks", 32'(banks_ready), 32'(0));
    chk("drained_err", 32'(err_sticky), 32'(0));

    // Read on an empty ring
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rdempty_err", 32'(err_sticky), 32'(1));
    chk("rdempty_rd_bank", 32'(rd_bank), m_rd_bank);
    chk("rdempty_banks", 32'(banks_ready), 32'(0));
    tick();
    chk("err_sticky_hold", 32'(err_sticky), 32'(1));
    do_reset();
    chk("rst2_err", 32'(err_sticky), 32'(0));
    chk("rst2_rd_bank", 32'(rd_bank), 32'(0));

    // Release of a FILLING bank, then reset mid-fill
    write_beats(3, 1'b0, 1'b0);
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    chk("relfill_err", 32'(err_sticky), 32'(1));
    chk("relfill_rd_bank", 32'(rd_bank), 32'(0));
    chk("relfill_wr_ready", 32'(wr_ready), 32'(1));
    chk("relfill_banks", 32'(banks_ready), 32'(0));
    do_reset();
    chk("rst3_wr_ready", 32'(wr_ready), 32'(1));
    chk("rst3_wr_bank", 32'(wr_bank), 32'(0));
    chk("rst3_banks", 32'(banks_ready), 32'(0));
    chk("rst3_avail", 32'(rd_avail), 32'(0));
    chk("rst3_err", 32'(err_sticky), 32'(0));
    chk("rst3_len", 32'(rd_tile_len), 32'(0));
    write_beats(2, 1'b1, 1'b0);
    chk("post_rst_len", 32'(rd_tile_len), 32'(2));
    read_words(2, 1'b0, 1'b0);
    release_bank();

    // Bank full without wr_last stalls the tile
    write_beats(11, 1'b0, 1'b0);
    chk("af_5free", 32'(wr_almost_full), 32'(0));
    write_beats(1, 1'b0, 1'b0);
    chk("af_4free", 32'(wr_almost_full), 32'(1));
    write_beats(4, 1'b0, 1'b0);
    chk("full_wr_ready", 32'(wr_ready), 32'(0));
    wr_valid = 1'b1; wr_last = 1'b1; wr_data = 24'h0FFFFF;
    tick();
    tick();
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("full_no_commit", 32'(banks_ready), 32'(0));
    chk("full_no_done", 32'(wt_load_done), 32'(0));
    chk("full_wr_bank", 32'(wr_bank), m_wr_bank);
    do_reset();
    write_beats(16, 1'b1, 1'b0);
    chk("full_tile_len", 32'(rd_tile_len), 32'(16));
    read_words(16, 1'b0, 1'b0);
    chk("full_tile_done", 32'(rd_tile_done), 32'(1));
    release_bank();

    tick();
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_bank_ring.md
Name: weight_bank_ring

Overview:
Parametrised successor to the two-bank weight FIFO: an N-bank ring of weight tile buffers between the DMA write path and the systolic-array weight loader. Each bank holds one tile and moves through EMPTY -> FILLING -> READY -> DRAINING -> EMPTY. Explicit commit, release and rewind handshakes let one tile be replayed across several activation passes while later tiles are prefetched. Replaces the single wt_buf_sel mux with independent producer and consumer bank pointers.

Parameters:
DATA_WIDTH, 24, bits per weight word (3 x int8)
DEPTH, 4096, words per bank
ADDR_WIDTH, $clog2(DEPTH), word address width
NUM_BANKS, 2, number of banks; legal 2..8
BANK_W, $clog2(NUM_BANKS) (min 1), bank index width
AF_TH, 4, almost-full threshold in free words
AE_TH, 4, almost-empty threshold in unread words

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  write beat valid
wr_data  in  DATA_WIDTH  weight word
wr_last  in  1  last beat of tile; commits the bank
wr_ready  out  1  beat accepted when wr_valid && wr_ready
wr_almost_full  out  1  fill bank free words <= AF_TH
wt_load_done  out  1  one-cycle pulse on commit
wr_bank  out  BANK_W  bank currently being filled
rd_en  in  1  read request; honoured only when rd_avail
rd_rewind  in  1  reset current bank read pointer to 0
rd_release  in  1  free current bank, advance consumer pointer
rd_avail  out  1  current bank READY/DRAINING with unread words
rd_data  out  DATA_WIDTH  read word, registered
rd_dvalid  out  1  rd_data valid (1 cycle after accepted rd_en)
rd_almost_empty  out  1  unread words in current bank <= AE_TH
rd_tile_done  out  1  all words of current bank read
rd_bank  out  BANK_W  bank currently being consumed
rd_tile_len  out  ADDR_WIDTH+1  committed length of current bank
banks_ready  out  BANK_W+1  banks in READY or DRAINING
err_sticky  out  1  set on protocol error, cleared only by rst

Behaviour:
- Reset (rst high at posedge): all banks EMPTY, pointers/lengths 0; wr_bank=0, rd_bank=0; outputs 0 except wr_ready=1. Reset mid-fill or mid-drain discards all data.
- Per bank: state, len[ADDR_WIDTH:0]. One write pointer (fill bank), one read pointer (drain bank).
- Write: wr_ready = fill bank EMPTY/FILLING && wr_cnt < DEPTH. Accepted beat writes mem[wr_bank][wr_cnt], wr_cnt++, EMPTY->FILLING.
- Accepted beat with wr_last: len <= wr_cnt+1, bank -> READY, wt_load_done pulses next cycle, wr_bank advances mod NUM_BANKS, wr_cnt <= 0. Minimum tile length 1.
- Bank full (wr_cnt==DEPTH) without wr_last: wr_ready=0; tile stalls until wr_last. Last accepted beat must carry wr_last; no overflow write ever occurs.
- Next fill bank not EMPTY (ring full): wr_ready=0 until released.
- Read: rd_avail = drain bank READY/DRAINING && rd_ptr < len. Accepted rd_en: rd_data <= mem[rd_bank][rd_ptr], rd_dvalid=1 next cycle, rd_ptr++, READY->DRAINING. rd_en while !rd_avail: ignored, err_sticky set.
- rd_tile_done = bank DRAINING && rd_ptr == len.
- rd_rewind: rd_ptr <= 0 (replay); state unchanged. A rd_en accepted in the same cycle reads the old address; pointer still becomes 0.
- rd_release: drain bank -> EMPTY, rd_ptr <= 0, rd_bank advances. Release of EMPTY/FILLING bank: ignored, err_sticky set. Release + rewind: release wins. Release + accepted rd_en: read completes, then release.
- Commit and release same cycle on different banks: both apply; banks_ready +1-1. Same bank impossible (a bank cannot be FILLING and draining).
- Wrap: both bank pointers wrap NUM_BANKS-1 -> 0; non-power-of-two NUM_BANKS supported.
- wr_almost_full, rd_almost_empty, banks_ready: combinational from registered state.
- Memory is single-write, single-read per cycle; inferred block RAM per bank.

Decomposition:
- weight_buf_pkg: bank_state_e (EMPTY, FILLING, READY, DRAINING), tile length type, error code constants.
- Sub-module wbr_bank_ram: one simple dual-port RAM (DEPTH x DATA_WIDTH, registered read), instantiated NUM_BANKS times via generate; top holds pointers, state and handshakes.

Test Plan:
- Reset, write 16 words with wr_last on the 16th -> wt_load_done pulse, banks_ready=1, rd_tile_len=16; 16 reads return the words in order, rd_dvalid 1 cycle after each rd_en, rd_tile_done after the 16th.
- NUM_BANKS=3: commit 3 tiles without reading -> wr_ready=0; rd_release -> wr_ready=1 next cycle, wr_bank=0 (wrap).
- DEPTH=8: 8 beats, no wr_last -> wr_ready=0, no write of beat 9; 9th beat with wr_last is not accepted; rd_tile_len=8 once the 8th beat carries wr_last.
- Read 5 of 10, rd_rewind, read 10 -> words 0..9 again; rd_release -> rd_bank advances, err_sticky=0.
- rd_en on empty ring and rd_release on FILLING bank -> no state change, err_sticky=1 until rst.
- Commit tile B same cycle as release of tile A; assert rst mid-fill -> banks_ready unchanged after commit/release, all EMPTY after rst.
